tlc_input_conditioner: RTL and testbench

//  Upstream input stage for the traffic light controller. Supplies its sensor1, sensor2 and peak inputs.
//  - Synchronises and debounces the two raw road-side vehicle sensors.
//  - Keeps a time-of-day minute counter and derives peak from a programmable window.
//  - Peak can be overridden manually; a stuck-sensor fault flag is raised per sensor.

---
 rtl/tlc_pkg.sv | 23 ++
 rtl/tlc_debounce.sv | 52 +++++
 rtl/tlc_input_conditioner.sv | 123 ++++++++++++
 tb/tb_tlc_input_conditioner.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic light controller slice: light encoding,
// default time-of-day sizing and the peak-window membership rule.
package tlc_pkg;

  typedef enum logic [1:0] {
    GREEN = 2'd0,
    AMBER = 2'd1,
    RED   = 2'd2
  } light_t;

  localparam int DAY_MINUTES_DEF = 1440;
  localparam int MINW            = 11;

  // A window with start > end wraps through midnight; start == end is empty.
  function automatic logic peak_window_hit(input int minute,
                                           input int start_min,
                                           input int end_min);
    if (start_min <= end_min)
      return (minute >= start_min) && (minute < end_min);
    return (minute >= start_min) || (minute < end_min);
  endfunction

endpackage

// File: rtl/tlc_debounce.sv
// Two-flop synchroniser followed by a stability counter; the output only
// follows the synced input after DEBOUNCE_CYCLES consecutive differing cycles.
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic debounced
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_reg;
  logic          sync2_reg;
  logic          out_reg;
  logic          out_next;
  logic [CW-1:0] cnt_reg;
  logic [CW-1:0] cnt_next;

  // Any cycle where synced and output agree restarts the stability count.
  always_comb begin
    cnt_next = '0;
    out_next = out_reg;
    if (sync2_reg != out_reg) begin
      if (cnt_reg == CNT_LAST)
        out_next = sync2_reg;
      else
        cnt_next = cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      cnt_reg   <= '0;
      out_reg   <= 1'b0;
    end else begin
      sync1_reg <= raw;
      sync2_reg <= sync1_reg;
      cnt_reg   <= cnt_next;
      out_reg   <= out_next;
    end
  end

  assign debounced = out_reg;

endmodule

// File: rtl/tlc_input_conditioner.sv
// Input stage for the traffic light controller: debounced sensors, minute-of-day
// time base, programmable peak window with override, per-sensor stuck-high flags.
module tlc_input_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TICKS_PER_MIN   = 60,
  parameter int DAY_MINUTES     = DAY_MINUTES_DEF,
  parameter int PEAK_START_MIN  = 480,
  parameter int PEAK_END_MIN    = 600,
  parameter int STUCK_MIN       = 10,
  parameter int MINW            = tlc_pkg::MINW
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            sensor1_raw,
  input  logic            sensor2_raw,
  input  logic            peak_ovr_en,
  input  logic            peak_ovr_val,
  input  logic            time_load,
  input  logic [MINW-1:0] time_load_min,
  output logic            sensor1,
  output logic            sensor2,
  output logic            peak,
  output logic [MINW-1:0] minute_of_day,
  output logic [1:0]      sensor_fault,
  output logic            load_err
);

  localparam int TW = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
  localparam int SW = (STUCK_MIN > 0) ? $clog2(STUCK_MIN + 1) : 1;
  localparam logic [TW-1:0]   TICK_LAST   = TW'(TICKS_PER_MIN - 1);
  localparam logic [MINW-1:0] MINUTE_LAST = MINW'(DAY_MINUTES - 1);
  localparam logic [SW-1:0]   STUCK_SAT   = SW'(STUCK_MIN);

  logic [TW-1:0]   tick_reg;
  logic [TW-1:0]   tick_next;
  logic [MINW-1:0] minute_reg;
  logic [MINW-1:0] minute_next;
  logic            peak_reg;
  logic            peak_next;
  logic            load_err_reg;
  logic            load_ok;
  logic            load_bad;
  logic            minute_step;
  logic [1:0]      raw_vec;
  logic [1:0]      deb_vec;
  logic [1:0]      fault_vec;

  assign raw_vec     = {sensor2_raw, sensor1_raw};
  assign load_ok     = time_load && (time_load_min <= MINUTE_LAST);
  assign load_bad    = time_load && !load_ok;
  // A valid load replaces the rollover, so it never counts toward stuck time.
  assign minute_step = (tick_reg == TICK_LAST) && !load_ok;

  always_comb begin
    tick_next   = tick_reg + 1'b1;
    minute_next = minute_reg;
    if (load_ok) begin
      tick_next   = '0;
      minute_next = time_load_min;
    end else if (tick_reg == TICK_LAST) begin
      tick_next   = '0;
      minute_next = (minute_reg == MINUTE_LAST) ? '0 : minute_reg + 1'b1;
    end
  end

  always_comb begin
    peak_next = peak_window_hit(int'(minute_reg), PEAK_START_MIN, PEAK_END_MIN);
    if (peak_ovr_en)
      peak_next = peak_ovr_val;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_reg     <= '0;
      minute_reg   <= '0;
      peak_reg     <= 1'b0;
      load_err_reg <= 1'b0;
    end else begin
      tick_reg     <= tick_next;
      minute_reg   <= minute_next;
      peak_reg     <= peak_next;
      load_err_reg <= load_bad;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_sensor
    logic [SW-1:0] stuck_reg;
    logic          fault_reg;

    tlc_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_vec[gi]),
      .debounced(deb_vec[gi])
    );

    // Counts whole minutes spent high; saturates so the flag stays set.
    always_ff @(posedge clk) begin
      if (!reset || !deb_vec[gi]) begin
        stuck_reg <= '0;
        fault_reg <= 1'b0;
      end else if (minute_step && (stuck_reg != STUCK_SAT)) begin
        stuck_reg <= stuck_reg + 1'b1;
        if ((stuck_reg + 1'b1) == STUCK_SAT)
          fault_reg <= 1'b1;
      end
    end

    assign fault_vec[gi] = fault_reg;
  end

  assign sensor1       = deb_vec[0];
  assign sensor2       = deb_vec[1];
  assign peak          = peak_reg;
  assign minute_of_day = minute_reg;
  assign sensor_fault  = fault_vec;
  assign load_err      = load_err_reg;

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// Directed and randomized bench for tlc_input_conditioner, checked every cycle
// against a history-based reference model (two builds: normal and wrapping window).
module tb_tlc_input_conditioner;

  localparam int D   = 4;
  localparam int T   = 4;
  localparam int DAY = 8;
  localparam int PS  = 3;
  localparam int PE  = 5;
  localparam int PSW = 6;
  localparam int PEW = 2;
  localparam int STK = 2;
  localparam int MW  = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          s1raw = 1'b0;
  logic          s2raw = 1'b0;
  logic          ovr_en = 1'b0;
  logic          ovr_val = 1'b0;
  logic          tload = 1'b0;
  logic [MW-1:0] tload_min = '0;

  logic          sensor1, sensor2, peak, load_err;
  logic [MW-1:0] minute_of_day;
  logic [1:0]    sensor_fault;
  logic          w_sensor1, w_sensor2, w_peak, w_load_err;
  logic [MW-1:0] w_minute_of_day;
  logic [1:0]    w_sensor_fault;

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [1:0] rawq[$];
  logic [1:0] synq[$];
  logic [1:0] m_out = '0;
  logic [1:0] m_fault = '0;
  int         m_stuck[2] = '{0, 0};
  int         m_tick = 0;
  int         m_min = 0;
  logic       m_peak = 1'b0;
  logic       m_peak_w = 1'b0;
  logic       m_lerr = 1'b0;

  tlc_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .TICKS_PER_MIN(T), .DAY_MINUTES(DAY),
    .PEAK_START_MIN(PS), .PEAK_END_MIN(PE), .STUCK_MIN(STK), .MINW(MW)
  ) u_dut (
    .clk(clk), .reset(reset), .sensor1_raw(s1raw), .sensor2_raw(s2raw),
    .peak_ovr_en(ovr_en), .peak_ovr_val(ovr_val), .time_load(tload),
    .time_load_min(tload_min), .sensor1(sensor1), .sensor2(sensor2),
    .peak(peak), .minute_of_day(minute_of_day), .sensor_fault(sensor_fault),
    .load_err(load_err)
  );

  tlc_input_conditioner #(
    .DEBOUNCE_CYCLES(D), .TICKS_PER_MIN(T), .DAY_MINUTES(DAY),
    .PEAK_START_MIN(PSW), .PEAK_END_MIN(PEW), .STUCK_MIN(STK), .MINW(MW)
  ) u_dut_wrap (
    .clk(clk), .reset(reset), .sensor1_raw(s1raw), .sensor2_raw(s2raw),
    .peak_ovr_en(ovr_en), .peak_ovr_val(ovr_val), .time_load(tload),
    .time_load_min(tload_min), .sensor1(w_sensor1), .sensor2(w_sensor2),
    .peak(w_peak), .minute_of_day(w_minute_of_day), .sensor_fault(w_sensor_fault),
    .load_err(w_load_err)
  );

  always #5 clk = ~clk;

  function automatic logic in_win(int m, int s, int e);
    if (s <= e) return (m >= s) && (m < e);
    return (m >= s) || (m < e);
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Applies one clock edge to the model, given the inputs seen at that edge.
  task automatic model_edge(logic r, logic [1:0] raw, logic oe, logic ov, logic tl, int tlm);
    logic       load_ok;
    logic       roll;
    logic [1:0] synced;
    logic       all_diff;
    if (!r) begin
      rawq.delete();
      synq.delete();
      m_out = '0; m_fault = '0; m_stuck[0] = 0; m_stuck[1] = 0;
      m_tick = 0; m_min = 0; m_peak = 0; m_peak_w = 0; m_lerr = 0;
      return;
    end
    load_ok  = tl && (tlm < DAY);
    roll     = (m_tick == T - 1) && !load_ok;
    m_lerr   = tl && !load_ok;
    m_peak   = oe ? ov : in_win(m_min, PS, PE);
    m_peak_w = oe ? ov : in_win(m_min, PSW, PEW);
    for (int s = 0; s < 2; s++) begin
      if (!m_out[s]) begin
        m_stuck[s] = 0;
        m_fault[s] = 1'b0;
      end else if (roll && m_stuck[s] < STK) begin
        m_stuck[s]++;
        m_fault[s] = (m_stuck[s] >= STK);
      end
    end
    if (load_ok) begin
      m_min = tlm; m_tick = 0;
    end else if (m_tick == T - 1) begin
      m_tick = 0; m_min = (m_min + 1) % DAY;
    end else begin
      m_tick++;
    end
    // Synced value seen at this edge is the raw sample from two edges back.
    synced = (rawq.size() >= 2) ? rawq[rawq.size() - 2] : 2'b00;
    synq.push_back(synced);
    for (int s = 0; s < 2; s++) begin
      if (synq.size() >= D) begin
        all_diff = 1'b1;
        for (int k = 0; k < D; k++)
          if (synq[synq.size() - 1 - k][s] == m_out[s]) all_diff = 1'b0;
        if (all_diff) m_out[s] = ~m_out[s];
      end
    end
    rawq.push_back(raw);
    if (rawq.size() > 4) void'(rawq.pop_front());
    if (synq.size() > 2 * D) void'(synq.pop_front());
  endtask

  task automatic step();
    logic       r, oe, ov, tl;
    logic [1:0] raw;
    int         tlm;
    r = reset; raw = {s2raw, s1raw}; oe = ovr_en; ov = ovr_val; tl = tload;
    tlm = int'(tload_min);
    @(posedge clk);
    model_edge(r, raw, oe, ov, tl, tlm);
    #1;
    check("sensor1", sensor1, m_out[0]);
    check("sensor2", sensor2, m_out[1]);
    check("peak", peak, m_peak);
    check("minute", minute_of_day, m_min);
    check("fault", sensor_fault, m_fault);
    check("load_err", load_err, m_lerr);
    check("wrap_peak", w_peak, m_peak_w);
    check("wrap_minute", w_minute_of_day, m_min);
    check("wrap_sensors", {w_sensor_fault, w_sensor2, w_sensor1}, {m_fault, m_out});
  endtask

  initial begin
    // Reset and time base start
    reset = 1'b0;
    repeat (3) step();
    check("reset_outputs", {sensor1, sensor2, peak, minute_of_day, sensor_fault, load_err}, 0);
    reset = 1'b1;
    repeat (3) step();
    check("minute_pre_tick", minute_of_day, 0);
    step();
    check("minute_first_tick", minute_of_day, 1);

    // Glitch rejection and debounce latency
    s1raw = 1'b1;
    repeat (3) step();
    s1raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("glitch_rejected", sensor1, 0);
    end
    s1raw = 1'b1;
    repeat (5) step();
    check("debounce_not_yet", sensor1, 0);
    step();
    check("debounce_latency", sensor1, 1);
    s1raw = 1'b0;
    repeat (8) step();
    check("sensor1_release", sensor1, 0);

    // Free run across a day wrap; wrapped window build
    for (int i = 0; i < 40 && m_min != 6; i++) step();
    step();
    check("wrap_peak_min6", w_peak, 1);
    for (int i = 0; i < 40 && m_min != 2; i++) step();
    step();
    check("wrap_peak_min2", w_peak, 0);
    for (int i = 0; i < 40 && m_min != 3; i++) step();
    step();
    check("peak_min3", peak, 1);
    repeat (40) step();

    // Out-of-range load, then load on a rollover cycle
    tload = 1'b1; tload_min = 4'd9;
    step();
    tload = 1'b0;
    check("load_err_pulse", load_err, 1);
    step();
    check("load_err_clear", load_err, 0);
    for (int i = 0; i < T && m_tick != T - 1; i++) step();
    tload = 1'b1; tload_min = 4'd4;
    step();
    tload = 1'b0;
    check("load_on_rollover", minute_of_day, 4);
    repeat (T - 1) step();
    check("load_tick_zero", minute_of_day, 4);
    step();
    check("load_next_minute", minute_of_day, 5);

    // Stuck sensor fault and release
    s2raw = 1'b1;
    repeat (30) step();
    check("stuck_fault_set", sensor_fault, 2'b10);
    s2raw = 1'b0;
    repeat (8) step();
    check("stuck_fault_clear", sensor_fault, 2'b00);

    // Peak override inside the window
    for (int i = 0; i < 40 && m_min != 3; i++) step();
    ovr_en = 1'b1; ovr_val = 1'b0;
    step();
    check("override_low", peak, 0);
    ovr_val = 1'b1;
    step();
    check("override_high", peak, 1);
    ovr_en = 1'b0;

    // Randomized traffic, loads, overrides and occasional resets
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(99) < 15) s1raw = ~s1raw;
      if ($urandom_range(99) < 4) s2raw = ~s2raw;
      if ($urandom_range(49) == 0) ovr_en = ~ovr_en;
      ovr_val   = 1'($urandom_range(1));
      tload     = ($urandom_range(24) == 0);
      tload_min = MW'($urandom_range(15));
      reset     = ($urandom_range(199) != 0);
      step();
    end
    reset = 1'b1; tload = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
